// File: rtl/gray_seq_gen.sv
// gray_seq_gen: emits a run of consecutive Gray codes over a valid/ready
// stream. The run counts up or down from a binary start value and wraps
// modulo 2^WIDTH. A one-cycle done pulse follows the last transfer.
// Every output comes straight from a flop.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             up,
  input  logic [WIDTH-1:0] start_bin,
  input  logic [WIDTH:0]   len,
  output logic [WIDTH-1:0] gray_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             wrap_o,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] B_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] B_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] B_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]   REM_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   REM_ZERO = {(WIDTH+1){1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             xfer;
  logic [WIDTH-1:0] b_step;
  logic             step_wraps;

  // A code leaves the block only while it is valid and downstream is ready.
  assign xfer = valid_q & ready_i;

  // The next binary value in the latched direction. The wrap flag marks a step
  // across the all-ones/all-zeros boundary.
  assign b_step     = dir_q ? (b_q + B_ONE) : (b_q - B_ONE);
  assign step_wraps = dir_q ? (b_q == B_MAX) : (b_q == B_ZERO);

  // The Gray code of the next binary count: each bit is the XOR of two
  // neighbouring binary bits, and the MSB passes through unchanged.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_d[gi] = b_d[gi] ^ b_d[gi+1];
    end
  endgenerate
  assign gray_d[WIDTH-1] = b_d[WIDTH-1];

  // Next-state logic. State holds by default, so a stalled code never changes.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    wrap_d  = wrap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != REM_ZERO) begin
            // Load the run. Its first code is never a wrap.
            b_d     = start_bin;
            rem_d   = len;
            dir_d   = up;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            wrap_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            // An empty run goes straight to the done pulse.
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_RUN: begin
        if (xfer) begin
          if (rem_q > REM_ONE) begin
            b_d    = b_step;
            rem_d  = rem_q - REM_ONE;
            wrap_d = step_wraps;
          end else begin
            // The last code was taken. gray_o keeps that code.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and active-low, and it
  // abandons any run in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      b_q     <= B_ZERO;
      rem_q   <= REM_ZERO;
      dir_q   <= 1'b0;
      gray_q  <= B_ZERO;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gray_o  = gray_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/gray_seq_gen.md
# gray_seq_gen

Registered Gray-code sequence generator that emits a programmable run of consecutive 4-bit (parameterisable) Gray codes over a valid/ready stream. It sits directly upstream of the Gray-to-binary converter stage and supplies its `i` input. It counts up or down from a binary start value, wraps modulo 2^WIDTH, and signals run completion.

## Interface
- WIDTH, 4, code width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a run; honoured only in IDLE
- up  input  1  direction, 1 = increment, 0 = decrement; sampled with start
- start_bin  input  WIDTH  binary value of the first code; sampled with start
- len  input  WIDTH+1  number of codes in the run, 0..2^WIDTH; sampled with start
- gray_o  output  WIDTH  current Gray code, gray_o = b ^ (b >> 1)
- valid_o  output  1  gray_o holds a code to be transferred
- ready_i  input  1  downstream accepts gray_o this cycle
- wrap_o  output  1  current code follows a modulo wrap (valid only with valid_o)
- busy  output  1  run in progress
- done  output  1  one-cycle pulse, run finished

## Operation
- Reset and synchronisation are fixed: one clock; reset is synchronous and active-low.
- All outputs are registered. Reset values: gray_o=0, valid_o=0, wrap_o=0, busy=0, done=0, state IDLE.
- Internal state: binary count register b (WIDTH bits), remaining counter rem (WIDTH+1 bits), latched direction dir, and FSM state IDLE/RUN/DONE.
- IDLE: start=1 and len≥1 → b=start_bin, rem=len, dir=up, state RUN. start=1 and len=0 → state DONE without emitting a code. start=0 → remain in IDLE.
- RUN: valid_o=1 and busy=1. A transfer is valid_o & ready_i.
  - Transfer with rem>1: b = b±1 mod 2^WIDTH, rem = rem−1. The run stays in RUN.
  - Transfer with rem==1: state DONE.
  - No transfer: gray_o, wrap_o, b, and rem hold. valid_o stays high; the code is never retracted.
- DONE: done=1, busy=0, valid_o=0. Next cycle → IDLE.
- wrap_o is 1 when the presented code was reached by stepping across the boundary: up from 2^WIDTH−1 to 0, or down from 0 to 2^WIDTH−1. The first code of a run always has wrap_o=0.
- start, up, start_bin, and len are ignored outside IDLE. This includes start in RUN or DONE.
- gray_o holds the last emitted code while valid_o=0.
- Consecutive emitted codes always differ in exactly one bit.

## Timing
- start accepted at cycle t → valid_o=1, busy=1, gray_o=Gray(start_bin) at t+1.
- Throughput: one code per cycle with ready_i held high. A transfer at cycle k presents the next code at k+1.
- Last transfer at cycle k → at k+1: valid_o=0, busy=0, done=1. At k+2: done=0 and state IDLE, so start is accepted at k+2.
- len=0: start at t → done=1 at t+1, with valid_o and busy staying 0.
- Run of length N with ready_i always 1: the busy window is N cycles, and start-to-done latency is N+1.
- rst_n low at any edge, including mid-run with a pending un-transferred code, forces all reset values at the next edge. The run is abandoned and done is not pulsed.
- ready_i has no effect when valid_o=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles mid-run → gray_o=0000, valid_o=0, busy=0, done=0, wrap_o=0. Then start accepted 1 cycle after release.
- Up run: start_bin=0, len=8, up=1, ready_i=1 → gray_o 0000,0001,0011,0010,0110,0111,0101,0100 on 8 consecutive cycles. done pulses the cycle after 0100, and wrap_o is 0 throughout.
- Down wrap: start_bin=1, len=3, up=0 → 0001,0000,1000, with wrap_o=1 only on 1000. Up from start_bin=15, len=2 → 1000,0000, with wrap_o=1 on 0000.
- Backpressure: run start_bin=4, len=3 with ready_i=0 for 3 cycles after the first valid → gray_o holds 0110 and valid_o stays 1. Then 0111,0101 follow, and exactly 3 transfers occur.
- Full cycle and edge lengths: len=16 from 0 → all 16 codes, each differing from the previous one in one bit, ending at 1000. len=0 → done at t+1 with no valid_o.
- Ignored start: pulse start with start_bin=9 during RUN and during DONE → the sequence is unaffected and no second run begins until start is asserted in IDLE.
